// File: rtl/reg_stack_file.sv
// Multi-ported general-purpose register file with an integrated return-address stack.
// Two combinational read ports, one write port, and push/pop of the PC with sticky error flags.
module reg_stack_file #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 16,
  parameter int ZERO_REG    = 0,
  parameter int BYPASS      = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               regwrite,
  input  logic [$clog2(NUM_REGS)-1:0]        ws,
  input  logic [DATA_W-1:0]                  wd,
  input  logic [$clog2(NUM_REGS)-1:0]        rs1,
  input  logic [$clog2(NUM_REGS)-1:0]        rs2,
  output logic [DATA_W-1:0]                  rd1,
  output logic [DATA_W-1:0]                  rd2,
  input  logic                               push,
  input  logic                               pop,
  input  logic [PC_W-1:0]                    push_pc,
  output logic [PC_W-1:0]                    pop_pc,
  output logic                               pop_valid,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_empty,
  output logic                               stack_full,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  localparam int AW  = $clog2(NUM_REGS);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SAW = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_ZERO = SPW'(0);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  logic [DATA_W-1:0] regs_r      [NUM_REGS];
  logic [PC_W-1:0]   stack_mem_r [STACK_DEPTH];

  logic [SPW-1:0]  sp_r;
  logic [PC_W-1:0] pop_pc_r;
  logic            pop_valid_r;
  logic            ovf_r;
  logic            unf_r;

  logic [SPW-1:0]  sp_dec_s;
  logic [SAW-1:0]  top_idx_s;
  logic [SAW-1:0]  push_idx_s;
  logic            empty_s;
  logic            full_s;

  logic            stk_we_s;
  logic [SAW-1:0]  stk_widx_s;
  logic [SPW-1:0]  sp_next_s;
  logic [PC_W-1:0] pop_pc_next_s;
  logic            pop_valid_next_s;
  logic            ovf_next_s;
  logic            unf_next_s;
  logic            reg_we_s;

  assign sp_dec_s   = sp_r - SP_ONE;
  assign top_idx_s  = sp_dec_s[SAW-1:0];
  assign push_idx_s = sp_r[SAW-1:0];
  assign empty_s    = (sp_r == SP_ZERO);
  assign full_s     = (sp_r == SP_FULL);

  assign sp          = sp_r;
  assign stack_empty = empty_s;
  assign stack_full  = full_s;
  assign pop_pc      = pop_pc_r;
  assign pop_valid   = pop_valid_r;
  assign stack_ovf   = ovf_r;
  assign stack_unf   = unf_r;

  // Writes to r0 are dropped when it is hardwired to zero.
  assign reg_we_s = regwrite && !((ZERO_REG != 0) && (ws == '0));

  // Read port 1: hardwired zero, then same-cycle forwarding, then the array.
  always_comb begin
    rd1 = regs_r[rs1];
    if ((ZERO_REG != 0) && (rs1 == '0)) begin
      rd1 = '0;
    end else if ((BYPASS != 0) && regwrite && (ws == rs1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_r[rs1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2 = regs_r[rs2];
    if ((ZERO_REG != 0) && (rs2 == '0)) begin
      rd2 = '0;
    end else if ((BYPASS != 0) && regwrite && (ws == rs2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_r[rs2];
    end
  end

  // Return-stack action decode; push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    stk_we_s         = 1'b0;
    stk_widx_s       = push_idx_s;
    sp_next_s        = sp_r;
    pop_pc_next_s    = pop_pc_r;
    pop_valid_next_s = 1'b0;
    ovf_next_s       = ovf_r;
    unf_next_s       = unf_r;
    case ({push, pop})
      2'b10: begin
        if (full_s) begin
          ovf_next_s = 1'b1;
        end else begin
          stk_we_s  = 1'b1;
          sp_next_s = sp_r + SP_ONE;
        end
      end
      2'b01: begin
        if (empty_s) begin
          unf_next_s = 1'b1;
        end else begin
          pop_pc_next_s    = stack_mem_r[top_idx_s];
          pop_valid_next_s = 1'b1;
          sp_next_s        = sp_dec_s;
        end
      end
      2'b11: begin
        pop_valid_next_s = 1'b1;
        if (empty_s) begin
          pop_pc_next_s = push_pc;
        end else begin
          pop_pc_next_s = stack_mem_r[top_idx_s];
          stk_we_s      = 1'b1;
          stk_widx_s    = top_idx_s;
        end
      end
      default: begin
        pop_valid_next_s = 1'b0;
      end
    endcase
  end

  // General-purpose register array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (reg_we_s) begin
      regs_r[ws] <= wd;
    end
  end

  // Stack memory needs no clearing; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (stk_we_s && !reset) begin
      stack_mem_r[stk_widx_s] <= push_pc;
    end
  end

  // Stack pointer, popped address and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r        <= SP_ZERO;
      pop_pc_r    <= '0;
      pop_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else begin
      sp_r        <= sp_next_s;
      pop_pc_r    <= pop_pc_next_s;
      pop_valid_r <= pop_valid_next_s;
      ovf_r       <= ovf_next_s;
      unf_r       <= unf_next_s;
    end
  end

endmodule

// File: tb/tb_reg_stack_file.sv
// Self-checking bench for reg_stack_file: directed scenarios plus randomized traffic
// against a queue-based reference model, on a default and a ZERO_REG=1/BYPASS=0 instance.
module tb_reg_stack_file;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        regwrite;
  logic [2:0]  ws;
  logic [31:0] wd;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic        push;
  logic        pop;
  logic [7:0]  push_pc;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [7:0]  pop_pc_a, pop_pc_b;
  logic        pop_valid_a, pop_valid_b;
  logic [4:0]  sp_a, sp_b;
  logic        empty_a, empty_b, full_a, full_b;
  logic        ovf_a, ovf_b, unf_a, unf_b;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] m_regs [2][8];
  int          m_stack [$];
  logic [7:0]  m_pop_pc;
  logic        m_pop_valid;
  logic        m_ovf;
  logic        m_unf;

  reg_stack_file u_dut_a (
    .clk(clk), .reset(reset), .regwrite(regwrite), .ws(ws), .wd(wd),
    .rs1(rs1), .rs2(rs2), .rd1(rd1_a), .rd2(rd2_a),
    .push(push), .pop(pop), .push_pc(push_pc),
    .pop_pc(pop_pc_a), .pop_valid(pop_valid_a), .sp(sp_a),
    .stack_empty(empty_a), .stack_full(full_a),
    .stack_ovf(ovf_a), .stack_unf(unf_a)
  );

  reg_stack_file #(.ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .regwrite(regwrite), .ws(ws), .wd(wd),
    .rs1(rs1), .rs2(rs2), .rd1(rd1_b), .rd2(rd2_b),
    .push(push), .pop(pop), .push_pc(push_pc),
    .pop_pc(pop_pc_b), .pop_valid(pop_valid_b), .sp(sp_b),
    .stack_empty(empty_b), .stack_full(full_b),
    .stack_ovf(ovf_b), .stack_unf(unf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance 0 has bypass and a writable r0; instance 1 hardwires r0 and has no bypass.
  function automatic logic [31:0] exp_rd(input int inst, input logic [2:0] idx);
    if (inst == 1 && idx == 3'd0) return 32'd0;
    if (inst == 0 && regwrite && ws == idx) return wd;
    return m_regs[inst][idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[0][i] = 32'd0;
      m_regs[1][i] = 32'd0;
    end
    m_stack.delete();
    m_pop_pc    = 8'd0;
    m_pop_valid = 1'b0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (regwrite) begin
        m_regs[0][ws] = wd;
        if (ws != 3'd0) m_regs[1][ws] = wd;
      end
      m_pop_valid = 1'b0;
      if (push && !pop) begin
        if (m_stack.size() == DEPTH) m_ovf = 1'b1;
        else m_stack.push_back(int'(push_pc));
      end else if (pop && !push) begin
        if (m_stack.size() == 0) begin
          m_unf = 1'b1;
        end else begin
          m_pop_pc    = 8'(m_stack.pop_back());
          m_pop_valid = 1'b1;
        end
      end else if (pop && push) begin
        m_pop_valid = 1'b1;
        if (m_stack.size() == 0) begin
          m_pop_pc = push_pc;
        end else begin
          m_pop_pc = 8'(m_stack.pop_back());
          m_stack.push_back(int'(push_pc));
        end
      end
    end
  endtask

  // One clock: drive at negedge, check reads, take the edge, check registered state.
  task automatic cycle(input logic rst, input logic we, input logic [2:0] w, input logic [31:0] d,
                       input logic [2:0] r1, input logic [2:0] r2,
                       input logic ps, input logic pp, input logic [7:0] pc);
    logic [4:0] exp_sp;
    @(negedge clk);
    reset = rst; regwrite = we; ws = w; wd = d; rs1 = r1; rs2 = r2;
    push = ps; pop = pp; push_pc = pc;
    #1;
    check_value("rd1_a", 64'(rd1_a), 64'(exp_rd(0, rs1)));
    check_value("rd2_a", 64'(rd2_a), 64'(exp_rd(0, rs2)));
    check_value("rd1_b", 64'(rd1_b), 64'(exp_rd(1, rs1)));
    check_value("rd2_b", 64'(rd2_b), 64'(exp_rd(1, rs2)));
    @(posedge clk);
    #1;
    model_edge();
    exp_sp = 5'(m_stack.size());
    check_value("sp", 64'(sp_a), 64'(exp_sp));
    check_value("stack_empty", 64'(empty_a), 64'(exp_sp == 5'd0));
    check_value("stack_full", 64'(full_a), 64'(exp_sp == 5'(DEPTH)));
    check_value("stack_ovf", 64'(ovf_a), 64'(m_ovf));
    check_value("stack_unf", 64'(unf_a), 64'(m_unf));
    check_value("pop_valid", 64'(pop_valid_a), 64'(m_pop_valid));
    check_value("pop_pc", 64'(pop_pc_a), 64'(m_pop_pc));
    check_value("stack_b", 64'({sp_b, empty_b, full_b, ovf_b, unf_b, pop_valid_b, pop_pc_b}),
                64'({sp_a, empty_a, full_a, ovf_a, unf_a, pop_valid_a, pop_pc_a}));
  endtask

  task automatic idle_push(input logic [7:0] pc);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b0, pc);
  endtask

  task automatic idle_pop();
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0);
  endtask

  initial begin
    int bias;
    checks = 0;
    failures = 0;
    reset = 1'b1; regwrite = 1'b0; ws = 3'd0; wd = 32'd0; rs1 = 3'd0; rs2 = 3'd0;
    push = 1'b0; pop = 1'b0; push_pc = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state and all indices read zero
    cycle(1'b1, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'(i), 3'(7 - i), 1'b0, 1'b0, 8'd0);
    end

    // Register writes, forwarding and the hardwired r0
    cycle(1'b0, 1'b1, 3'd1, 32'd25, 3'd4, 3'd5, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 3'd2, 32'd7, 3'd1, 3'd6, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd2, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 3'd3, 32'd9, 3'd3, 3'd1, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b1, 3'd0, 32'd5, 3'd0, 3'd3, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd3, 1'b0, 1'b0, 8'd0);

    // LIFO order
    idle_push(8'd35); idle_push(8'd40); idle_push(8'd45);
    idle_pop(); idle_pop(); idle_pop();

    // Fill, overflow attempt with 99, then drain
    for (int i = 0; i < DEPTH; i++) idle_push(8'(100 + i));
    idle_push(8'd99);
    idle_push(8'd98);
    for (int i = 0; i < DEPTH; i++) idle_pop();

    // Underflow, pass-through, replace-top
    idle_pop();
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1, 8'd12);
    idle_push(8'd35); idle_push(8'd40);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1, 8'd50);
    idle_pop(); idle_pop();

    // Full stack with simultaneous push+pop
    for (int i = 0; i < DEPTH; i++) idle_push(8'(200 + i));
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, 1'b1, 1'b1, 8'd77);
    idle_pop();

    // Reset mid-sequence with sp=5 and sticky flags set
    for (int i = 0; i < DEPTH; i++) idle_pop();
    for (int i = 0; i < 5; i++) idle_push(8'(60 + i));
    cycle(1'b1, 1'b1, 3'd4, 32'hDEAD, 3'd1, 3'd2, 1'b1, 1'b1, 8'd1);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd1, 3'd2, 1'b0, 1'b0, 8'd0);
    cycle(1'b0, 1'b0, 3'd0, 32'd0, 3'd3, 3'd0, 1'b0, 1'b0, 8'd0);

    // Randomized traffic with alternating push-heavy and pop-heavy phases
    for (int n = 0; n < 600; n++) begin
      bias = ((n / 40) % 2 == 0) ? 80 : 25;
      cycle(($urandom_range(249) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(1)),
            3'($urandom_range(7)),
            32'($urandom),
            3'($urandom_range(7)),
            3'($urandom_range(7)),
            ($urandom_range(99) < bias) ? 1'b1 : 1'b0,
            ($urandom_range(99) < (100 - bias)) ? 1'b1 : 1'b0,
            8'($urandom_range(255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_stack_file.md
# reg_stack_file

Parametrised successor to the CPU register file: a multi-ported general-purpose register file with an integrated hardware return-address stack for CALL/RET. It sits in the decode/writeback stage. It supplies two operands per cycle and accepts one writeback per cycle. It pushes or pops the program counter under control-unit command, with full/empty status and sticky overflow/underflow error flags that the previous generation lacked.

## Interface
Parameters:
- DATA_W, 32, register data width
- NUM_REGS, 8, number of GPRs; AW = $clog2(NUM_REGS)
- PC_W, 8, return-address width
- STACK_DEPTH, 16, return-stack entries (≥2); SPW = $clog2(STACK_DEPTH+1)
- ZERO_REG, 0, 1 = r0 reads as 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- regwrite  in  1  write enable for ws/wd
- ws  in  AW  write register index
- wd  in  DATA_W  write data
- rs1, rs2  in  AW  read indices
- rd1, rd2  out  DATA_W  combinational read data
- push  in  1  push push_pc onto return stack
- pop  in  1  pop top of return stack
- push_pc  in  PC_W  address to push
- pop_pc  out  PC_W  registered popped address
- pop_valid  out  1  one-cycle strobe, pop_pc updated this cycle
- sp  out  SPW  current stack occupancy (0..STACK_DEPTH)
- stack_empty, stack_full  out  1  sp==0 / sp==STACK_DEPTH
- stack_ovf, stack_unf  out  1  sticky error flags

## Operation
- Reset: all GPRs 0, sp=0, pop_pc=0, pop_valid=0, stack_empty=1, stack_full=0, stack_ovf=0, stack_unf=0. Stack memory contents need not clear. Reset overrides any same-cycle push/pop/regwrite.
- Write: on an edge with regwrite=1, reg[ws] <= wd. With ZERO_REG=1, writes to index 0 are dropped.
- Read: rdN = reg[rsN]. With BYPASS=1, regwrite=1, and ws==rsN (and not the zero-hardwired r0), rdN = wd in the same cycle. With BYPASS=0, rdN shows the new value the cycle after the write. With ZERO_REG=1, rsN==0 gives 0.
- Stack actions, per edge (exactly one applies):
  - push only, not full: stack[sp] <= push_pc, sp <= sp+1.
  - push only, full: push ignored, sp unchanged, stack_ovf <= 1.
  - pop only, not empty: pop_pc <= stack[sp-1], sp <= sp-1, pop_valid <= 1.
  - pop only, empty: pop_pc holds, pop_valid <= 0, stack_unf <= 1.
  - push and pop, not empty (full included): pop_pc <= stack[sp-1], stack[sp-1] <= push_pc, sp unchanged, pop_valid <= 1. No error.
  - push and pop, empty: pass-through, pop_pc <= push_pc, pop_valid <= 1, sp stays 0. No error.
  - neither: pop_valid <= 0, all else holds.
- stack_ovf and stack_unf stay set until reset.
- stack_empty and stack_full are combinational from sp.
- Register-file and stack operations are independent and may occur in the same cycle.

## Timing
- rd1/rd2: zero-cycle combinational from rs1/rs2, and from ws/wd/regwrite when BYPASS=1.
- Register write visible through the array one edge after regwrite.
- pop_pc/pop_valid: registered, valid in the cycle after the edge that samples pop. pop_valid is high for exactly one cycle per accepted pop.
- sp, stack_empty, stack_full, and the error flags update on the same edge as the action.
- Back-to-back pushes/pops are sustained at one per cycle. No stall or handshake: the control unit must consult stack_full/stack_empty.

## Test plan
- Reset, then read all indices: rd1=rd2=0, sp=0, stack_empty=1, flags 0, pop_valid=0.
- Write r1=25, r2=7. Read rs1=1, rs2=2 next cycle: rd1=25, rd2=7. Same-cycle write r3=9 with rs1=3: rd1=9 when BYPASS=1, old value when BYPASS=0. With ZERO_REG=1, write r0=5: rd of r0 stays 0.
- Push 35, 40, 45: sp=3. Then three pops: pop_pc = 45, 40, 35 on consecutive cycles, pop_valid high each. Ending sp=0, stack_empty=1.
- Fill to STACK_DEPTH (full=1), then push 99: sp unchanged, stack_ovf=1 and stays 1. Subsequent pops return the original entries; top is not 99.
- On empty, pop: pop_valid=0, pop_pc unchanged, stack_unf=1. Simultaneous push 12 + pop on empty: pop_pc=12, pop_valid=1, sp=0. With sp=2 (top 40), push 50 + pop: pop_pc=40, sp=2, next pop returns 50.
- Reset asserted mid-sequence with sp=5 and flags set: next cycle sp=0, empty=1, all flags 0, GPRs 0, pop_valid=0.
